// File: rtl/srv_inst_buf.sv
// Instruction buffer between fetch and dual-issue decode: fetch packets of up to two
// instructions are split into single entries of an in-order circular queue.
package srv_inst_buf_pkg;
    typedef struct packed {
        logic        i0_valid;
        logic [31:0] i0_inst;
        logic        i1_valid;
        logic [31:0] i1_inst;
        logic [31:0] addr;
    } inst_pkt_t;
endpackage

module srv_inst_buf
    import srv_inst_buf_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  inst_pkt_t        in_pkt,
    output logic             in_ready,
    input  logic [1:0]       issue_cnt,
    output logic             out_i0_valid,
    output logic [31:0]      out_i0_inst,
    output logic [31:0]      out_i0_addr,
    output logic             out_i1_valid,
    output logic [31:0]      out_i1_inst,
    output logic [31:0]      out_i1_addr,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a packet transfers on a rising edge when in_ready is high, at least one
    // slot valid is set and flush is low; fetch must hold the packet while in_ready is low.
    // in_ready depends only on registered occupancy, never on the same-cycle issue_cnt.

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_slot1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [31:0]      mem_inst [DEPTH];
    logic [31:0]      mem_addr [DEPTH];

    logic             push_en;
    logic [1:0]       pushed;
    logic [1:0]       issue_clamp;
    logic [1:0]       popped;
    logic [CNT_W-1:0] count_next;

    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign push_en  = in_ready && (in_pkt.i0_valid || in_pkt.i1_valid) && !flush;
    assign pushed   = {1'b0, in_pkt.i0_valid} + {1'b0, in_pkt.i1_valid};

    // i1 compacts down into wr_ptr when i0 is absent.
    assign wr_slot1  = in_pkt.i0_valid ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

    always_comb begin
        issue_clamp = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
        popped      = issue_clamp;
        if (count < CNT_W'(issue_clamp)) begin
            popped = count[1:0];
        end
        count_next = count + CNT_W'(push_en ? pushed : 2'd0) - CNT_W'(popped);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(pushed);
            end
            rd_ptr <= rd_ptr + PTR_W'(popped);
            count  <= count_next;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (in_pkt.i0_valid) begin
                mem_inst[wr_ptr] <= in_pkt.i0_inst;
                mem_addr[wr_ptr] <= in_pkt.addr;
            end
            if (in_pkt.i1_valid) begin
                mem_inst[wr_slot1] <= in_pkt.i1_inst;
                mem_addr[wr_slot1] <= in_pkt.addr + 32'd4;
            end
        end
    end

    assign out_i0_valid = (count >= CNT_W'(1));
    assign out_i1_valid = (count >= CNT_W'(2));
    assign out_i0_inst  = out_i0_valid ? mem_inst[rd_ptr]    : 32'd0;
    assign out_i0_addr  = out_i0_valid ? mem_addr[rd_ptr]    : 32'd0;
    assign out_i1_inst  = out_i1_valid ? mem_inst[rd_ptr_p1] : 32'd0;
    assign out_i1_addr  = out_i1_valid ? mem_addr[rd_ptr_p1] : 32'd0;

endmodule

// File: tb/tb_srv_inst_buf.sv
// Directed bench for srv_inst_buf: reset, dual/single push, address wrap, backpressure,
// partial issue, over-issue, flush priority and asynchronous reset.
module tb_srv_inst_buf;
    import srv_inst_buf_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    inst_pkt_t        in_pkt;
    logic             in_ready;
    logic [1:0]       issue_cnt;
    logic             out_i0_valid;
    logic [31:0]      out_i0_inst;
    logic [31:0]      out_i0_addr;
    logic             out_i1_valid;
    logic [31:0]      out_i1_inst;
    logic [31:0]      out_i1_addr;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;

    srv_inst_buf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_pkt       (in_pkt),
        .in_ready     (in_ready),
        .issue_cnt    (issue_cnt),
        .out_i0_valid (out_i0_valid),
        .out_i0_inst  (out_i0_inst),
        .out_i0_addr  (out_i0_addr),
        .out_i1_valid (out_i1_valid),
        .out_i1_inst  (out_i1_inst),
        .out_i1_addr  (out_i1_addr),
        .count        (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic set_pkt(input logic v0, input logic [31:0] i0, input logic v1,
                           input logic [31:0] i1, input logic [31:0] a);
        in_pkt.i0_valid = v0;
        in_pkt.i0_inst  = i0;
        in_pkt.i1_valid = v1;
        in_pkt.i1_inst  = i1;
        in_pkt.addr     = a;
    endtask

    task automatic idle();
        set_pkt(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        issue_cnt = 2'd0;
        flush     = 1'b0;
    endtask

    // advance one edge, then sample 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic rdy,
                             input logic v0, input logic v1);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".i0_valid"}, 32'(out_i0_valid), 32'(v0));
        chk({tag, ".i1_valid"}, 32'(out_i1_valid), 32'(v1));
    endtask

    task automatic chk_out(input string tag, input logic [31:0] i0, input logic [31:0] a0,
                           input logic [31:0] i1, input logic [31:0] a1);
        chk({tag, ".i0_inst"}, out_i0_inst, i0);
        chk({tag, ".i0_addr"}, out_i0_addr, a0);
        chk({tag, ".i1_inst"}, out_i1_inst, i1);
        chk({tag, ".i1_addr"}, out_i1_addr, a1);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // reset held 3 cycles under random stimulus
        for (int k = 0; k < 3; k++) begin
            set_pkt(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom);
            issue_cnt = 2'($urandom_range(0, 3));
            flush     = 1'($urandom_range(0, 1));
            step();
            chk_state("rst", 0, 1'b1, 1'b0, 1'b0);
            chk_out("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        end
        idle();
        rst_n = 1'b1;
        step();
        chk_state("post_rst", 0, 1'b1, 1'b0, 1'b0);

        // dual push
        set_pkt(1'b1, 32'h00A00093, 1'b1, 32'h00B00113, 32'h100);
        step();
        idle();
        chk_state("dual", 2, 1'b1, 1'b1, 1'b1);
        chk_out("dual", 32'h00A00093, 32'h100, 32'h00B00113, 32'h104);
        issue_cnt = 2'd2;
        step();
        idle();
        chk_state("dual_pop", 0, 1'b1, 1'b0, 1'b0);

        // single slot i1 only, compacted
        set_pkt(1'b0, 32'hDEADBEEF, 1'b1, 32'h00C00193, 32'h200);
        step();
        idle();
        chk_state("single", 1, 1'b1, 1'b1, 1'b0);
        chk_out("single", 32'h00C00193, 32'h204, 32'd0, 32'd0);
        issue_cnt = 2'd1;
        step();
        idle();
        chk_state("single_pop", 0, 1'b1, 1'b0, 1'b0);

        // address wrap past 2^32
        set_pkt(1'b1, 32'h11, 1'b1, 32'h22, 32'hFFFFFFFC);
        step();
        idle();
        chk_out("awrap", 32'h11, 32'hFFFFFFFC, 32'h22, 32'h0);
        issue_cnt = 2'd2;
        step();
        idle();
        chk_state("awrap_pop", 0, 1'b1, 1'b0, 1'b0);

        // fill to full across the pointer wrap
        for (int k = 0; k < 4; k++) begin
            set_pkt(1'b1, 32'h10000000 + 32'(2 * k), 1'b1, 32'h10000001 + 32'(2 * k),
                    32'h400 + 32'(8 * k));
            step();
        end
        set_pkt(1'b1, 32'h2000, 1'b1, 32'h2001, 32'h300);
        chk_state("full", 8, 1'b0, 1'b1, 1'b1);
        chk_out("full", 32'h10000000, 32'h400, 32'h10000001, 32'h404);
        step();
        step();
        chk_state("held", 8, 1'b0, 1'b1, 1'b1);
        issue_cnt = 2'd2;
        step();
        issue_cnt = 2'd0;
        chk_state("full_pop", 6, 1'b1, 1'b1, 1'b1);
        chk_out("full_pop", 32'h10000002, 32'h408, 32'h10000003, 32'h40C);
        step();
        idle();
        chk_state("held_acc", 8, 1'b0, 1'b1, 1'b1);
        issue_cnt = 2'd2;
        step();
        chk_out("drain1", 32'h10000004, 32'h410, 32'h10000005, 32'h414);
        step();
        chk_out("drain2", 32'h10000006, 32'h418, 32'h10000007, 32'h41C);
        step();
        chk_state("drain3", 2, 1'b1, 1'b1, 1'b1);
        chk_out("drain3", 32'h2000, 32'h300, 32'h2001, 32'h304);
        step();
        idle();
        chk_state("drained", 0, 1'b1, 1'b0, 1'b0);

        // partial issue with concurrent push
        set_pkt(1'b1, 32'hA1, 1'b1, 32'hB1, 32'h500);
        step();
        set_pkt(1'b1, 32'hC1, 1'b0, 32'h0, 32'h508);
        step();
        chk_state("abc", 3, 1'b1, 1'b1, 1'b1);
        set_pkt(1'b1, 32'hD1, 1'b1, 32'hE1, 32'h600);
        issue_cnt = 2'd1;
        step();
        idle();
        chk_state("partial", 4, 1'b1, 1'b1, 1'b1);
        chk_out("partial", 32'hB1, 32'h504, 32'hC1, 32'h508);
        issue_cnt = 2'd3;
        step();
        idle();
        chk_state("issue3", 2, 1'b1, 1'b1, 1'b1);
        chk_out("issue3", 32'hD1, 32'h600, 32'hE1, 32'h604);

        // packet with no valid slot changes nothing
        set_pkt(1'b0, 32'h99, 1'b0, 32'h98, 32'h700);
        step();
        idle();
        chk_state("novalid", 2, 1'b1, 1'b1, 1'b1);
        chk_out("novalid", 32'hD1, 32'h600, 32'hE1, 32'h604);

        // over-issue clamps at occupancy
        issue_cnt = 2'd1;
        step();
        issue_cnt = 2'd3;
        step();
        idle();
        chk_state("over_issue", 0, 1'b1, 1'b0, 1'b0);
        issue_cnt = 2'd2;
        step();
        idle();
        chk_state("empty_issue", 0, 1'b1, 1'b0, 1'b0);

        // flush beats push and pop
        set_pkt(1'b1, 32'h31, 1'b1, 32'h32, 32'h800);
        step();
        set_pkt(1'b1, 32'h33, 1'b1, 32'h34, 32'h808);
        step();
        set_pkt(1'b1, 32'h35, 1'b0, 32'h0, 32'h810);
        step();
        chk_state("pre_flush", 5, 1'b1, 1'b1, 1'b1);
        set_pkt(1'b1, 32'hF0, 1'b1, 32'hF1, 32'h900);
        issue_cnt = 2'd2;
        flush     = 1'b1;
        step();
        idle();
        chk_state("flush", 0, 1'b1, 1'b0, 1'b0);
        chk_out("flush", 32'd0, 32'd0, 32'd0, 32'd0);
        set_pkt(1'b1, 32'h77, 1'b0, 32'h0, 32'hA00);
        step();
        idle();
        chk_state("post_flush", 1, 1'b1, 1'b1, 1'b0);
        chk_out("post_flush", 32'h77, 32'hA00, 32'd0, 32'd0);

        // asynchronous reset mid-operation
        set_pkt(1'b1, 32'h55, 1'b1, 32'h66, 32'hB00);
        step();
        idle();
        chk_state("pre_areset", 3, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("areset", 0, 1'b1, 1'b0, 1'b0);
        chk_out("areset", 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk_state("areset_rel", 0, 1'b1, 1'b0, 1'b0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
